stream_mux_n: RTL
=================

// Module: stream_mux_n
// PURPOSE
//  N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake.
//  Generalises the 2:1 combinational mux: any channel count and data width, with a registered output.
//  Two selection modes: fixed (sel port) or round-robin across valid channels.
//  Sits between parallel producers and a single downstream consumer.
// PARAMETERS
//  N_CH   4  number of input channels; legal range >= 2
//  WIDTH  8  data width per channel, in bits; legal range >= 1
//  SELW   $clog2(N_CH)  select/channel-index width; derived, do not override
// PORTS
//  clk        in   1           rising-edge clock; the only clock
//  rst_n      in   1           asynchronous reset, active low
//  in_valid   in   N_CH        bit i: channel i holds a valid word
//  in_data    in   N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_ready   out  N_CH        bit i: channel i's word is accepted this cycle
//  sel        in   SELW        channel index used in fixed mode
//  mode       in   1           0 = fixed (sel), 1 = round-robin (needs macro)
//  out_valid  out  1           out_data/out_chan are valid
//  out_data   out  WIDTH       selected word, registered
//  out_chan   out  SELW        index of the channel that supplied out_data
//  out_ready  in   1           downstream accepts the word this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0; RR pointer last=N_CH-1.
//  - Transfer into the output register happens when load_en = (!out_valid || out_ready) AND a grant exists.
//  - in_ready[i] = load_en && (grant==i). At most one in_ready bit is high per cycle.
//    in_ready is combinational from in_valid, sel, mode and out_ready; it does not depend on in_data.
//  - Latency: input word appears at out_data 1 cycle after acceptance. Throughput: 1 word/cycle.
//  - Backpressure: while out_valid && !out_ready, out_data and out_chan hold stable and all in_ready=0.
//  - Same-edge pop and load: when out_valid && out_ready and a grant exists, out_valid stays 1 and the new word replaces the old one.
//  - If out_valid && out_ready and no grant exists, out_valid goes to 0 on the next edge.
//  - Fixed mode: grant = sel when in_valid[sel]=1.
//    sel >= N_CH (non-power-of-2 N_CH) gives no grant; the block never accepts from an out-of-range index.
//  - Changes to sel or mode affect only the next acceptance; a held output word is unaffected.
//  - Round-robin mode: search channels last+1, last+2, ... wrapping modulo N_CH.
//    The first channel with in_valid set wins. On transfer, last <- winner.
//    The pointer changes only on a transfer.
//  - No input valid gives no grant and no state change.
//  - Reset mid-operation discards the held word; the pointer returns to N_CH-1, so channel 0 has first priority.
// CONFIGURATION
//  STREAM_MUX_RR_EN defined: round-robin logic and pointer are compiled in; mode is honoured.
//  STREAM_MUX_RR_EN undefined: no pointer register; mode is ignored and fixed-sel behaviour always applies.
// TESTING
//  1. Reset: assert rst_n=0 mid-transfer -> out_valid=0, out_data=0, out_chan=0 immediately, without waiting for clk.
//  2. Fixed mode, N_CH=4, WIDTH=8:
//     sel=2, in_valid=4'b0100, in_data[23:16]=8'hA5, out_ready=1 -> in_ready=4'b0100;
//     next cycle out_valid=1, out_data=8'hA5, out_chan=2.
//  3. Backpressure: out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0 and out_data stable.
//     Raise out_ready -> pending word accepted on the same edge.
//  4. Round-robin (macro on, mode=1): in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0.
//     in_valid=4'b1010 -> sequence 1,3,1.
//  5. Out-of-range select: N_CH=3, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
//  6. Macro off: mode=1, sel=1 -> behaves exactly as fixed mode; only channel 1 is served.

Source files
------------

// File: rtl/stream_mux_n_if.sv
// Handshake bundle for stream_mux_n: N_CH parallel producer channels plus one registered output stream.
// master = the side that drives producers and the downstream ready; slave = the mux itself.
interface stream_mux_n_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N_CH)
);
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic [SELW-1:0]       sel;
    logic                  mode;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_chan;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, sel, mode, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, sel, mode, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux, fixed-select or round-robin (round-robin only with STREAM_MUX_RR_EN).
// Latency: 1 cycle from acceptance to out_data; throughput 1 word/cycle.
// Backpressure: output word holds while out_valid && !out_ready; all in_ready drop until it drains.
module stream_mux_n #(
    parameter int  N_CH  = 4,
    parameter int  WIDTH = 8,
    localparam int SELW  = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_mux_n_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;

    logic             fix_vld;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic             load_en;
    logic [WIDTH-1:0] gnt_data;

    // Loop compare instead of in_valid[sel] so an out-of-range sel can never grant.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[i]) fix_vld = 1'b1;
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0] last_q, last_d;
    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    int              dist;
    int              best;

    // Winner is the valid channel at the smallest distance past the last winner.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        best   = N_CH;
        dist   = 0;
        for (int i = 0; i < N_CH; i++) begin
            dist = (i + N_CH - 1 - int'(last_q)) % N_CH;
            if (bus.in_valid[i] && dist < best) begin
                best   = dist;
                rr_vld = 1'b1;
                rr_idx = SELW'(i);
            end
        end
    end

    always_comb begin
        gnt_vld = bus.mode ? rr_vld : fix_vld;
        gnt_idx = bus.mode ? rr_idx : bus.sel;
    end

    always_comb begin
        last_d = last_q;
        if (load_en && bus.mode) last_d = gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SELW'(N_CH - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;

    always_comb begin
        gnt_vld = fix_vld;
        gnt_idx = bus.sel;
    end
`endif

    assign load_en = (!out_valid_q || bus.out_ready) && gnt_vld;

    always_comb begin
        bus.in_ready = '0;
        gnt_data     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SELW'(i)) begin
                bus.in_ready[i] = load_en;
                gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (load_en) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule
